// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the IR decode stage it feeds.
// Holds the state encoding, instruction width and the fetch-accept rule.
package instr_fetch_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // A returning word is kept only when no redirect is pending or arriving with it.
    function automatic logic fetch_accept(
        input logic ack,
        input logic discard,
        input logic redirect
    );
        return ack && !discard && !redirect;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory read bus plus the instruction handshake towards decode.
// The master modport is the fetch stage; slave is memory plus decode.
interface instr_fetch_if #(
    parameter int AW = 8
) ();
    import instr_fetch_pkg::*;

    logic               mem_req;
    logic [AW-1:0]      mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: loads a redirect target or steps by one, wrapping modulo 2^AW.
// A load always beats an increment in the same cycle.
module instr_fetch_pc_reg #(
    parameter int          AW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= AW'(RESET_PC);
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues program-memory reads from the PC and presents
// each returned word to decode with a valid/ready handshake; supports redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          AW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_if.master    bus,
    input  logic             pc_load,
    input  logic [AW-1:0]    pc_target,
    input  logic             fetch_en
);

    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    fetch_state_t  state_reg;
    logic          discard_reg;
    logic [AW-1:0] pc;
    logic          pc_inc;

    // The PC only advances when a fetched word is actually delivered downstream.
    assign pc_inc = (state_reg == FETCH) && fetch_accept(bus.mem_ack, discard_reg, pc_load);

    instr_fetch_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (pc_target),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            discard_reg     <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= PC_RST;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!pc_load && fetch_en) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                        state_reg    <= FETCH;
                    end
                end

                FETCH: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        discard_reg <= 1'b0;
                        if (fetch_accept(bus.mem_ack, discard_reg, pc_load)) begin
                            bus.instr       <= bus.mem_rdata;
                            bus.instr_pc    <= bus.mem_addr;
                            bus.instr_valid <= 1'b1;
                            state_reg       <= HOLD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (pc_load) begin
                        // The bus request cannot be withdrawn; remember to drop its data.
                        discard_reg <= 1'b1;
                    end
                end

                HOLD: begin
                    if (pc_load) begin
                        bus.instr_valid <= 1'b0;
                        state_reg       <= IDLE;
                    end else if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        if (fetch_en) begin
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= pc;
                            state_reg    <= FETCH;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    bus.mem_req     <= 1'b0;
                    bus.instr_valid <= 1'b0;
                    discard_reg     <= 1'b0;
                    state_reg       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a memory responder, a transaction-level model
// of the fetch stage, a per-cycle compare process and directed literal checks.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_load = 1'b0;
    logic [AW-1:0] pc_target = '0;
    logic          fetch_en = 1'b0;

    instr_fetch_if #(.AW(AW)) bus ();

    instr_fetch #(
        .AW       (AW),
        .RESET_PC (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .fetch_en  (fetch_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem_img [256];
    int lat_min = 0;
    int lat_max = 0;
    bit stray_rand = 1'b0;
    bit force_stray = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmp(nm, 32'(bus.instr_valid), 1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmp(nm, 32'(bus.mem_req), 1);
    endtask

    // Program memory: answers a request after a random number of cycles, and
    // optionally pulses mem_ack when nothing is outstanding.
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(lat_max, lat_min));
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_img[bus.mem_addr];
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                    bus.mem_ack = 1'b0;
                    bus.mem_rdata = 16'($urandom);
                end
            end else begin
                wait_cnt = -1;
                bus.mem_ack = force_stray || (stray_rand && ($urandom % 4) == 0);
                bus.mem_rdata = 16'($urandom);
            end
        end
    end

    // Reference model: an outstanding read, a held instruction, or neither.
    bit          m_req, m_valid, m_drop;
    logic [7:0]  m_addr, m_ipc, m_pc;
    logic [15:0] m_instr;

    always @(posedge clk or negedge rst_n) begin : model
        bit          req, valid, drop;
        logic [7:0]  addr, ipc, pc;
        logic [15:0] ins;
        if (!rst_n) begin
            m_req   <= 1'b0;
            m_valid <= 1'b0;
            m_drop  <= 1'b0;
            m_addr  <= 8'h00;
            m_ipc   <= 8'h00;
            m_pc    <= 8'h00;
            m_instr <= 16'h0000;
        end else begin
            req = m_req; valid = m_valid; drop = m_drop;
            addr = m_addr; ipc = m_ipc; pc = m_pc; ins = m_instr;
            if (req) begin
                if (bus.mem_ack) begin
                    req = 1'b0;
                    if (!drop && !pc_load) begin
                        ins = bus.mem_rdata;
                        ipc = addr;
                        valid = 1'b1;
                        pc = pc + 8'd1;
                    end else begin
                        drop = 1'b0;
                        if (pc_load) pc = pc_target;
                    end
                end else if (pc_load) begin
                    pc = pc_target;
                    drop = 1'b1;
                end
            end else if (valid) begin
                if (pc_load) begin
                    valid = 1'b0;
                    pc = pc_target;
                end else if (bus.instr_ready) begin
                    valid = 1'b0;
                    if (fetch_en) begin
                        req = 1'b1;
                        addr = pc;
                    end
                end
            end else begin
                if (pc_load) begin
                    pc = pc_target;
                end else if (fetch_en) begin
                    req = 1'b1;
                    addr = pc;
                end
            end
            m_req <= req; m_valid <= valid; m_drop <= drop;
            m_addr <= addr; m_ipc <= ipc; m_pc <= pc; m_instr <= ins;
        end
    end

    always @(negedge clk) begin
        cmp("mem_req", 32'(bus.mem_req), 32'(m_req));
        cmp("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        cmp("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        cmp("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
        cmp("instr", 32'(bus.instr), 32'(m_instr));
        if (bus.instr_valid === 1'b1)
            cmp("instr_vs_memory", 32'(bus.instr), 32'(mem_img[bus.instr_pc]));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
        mem_img[8'h00] = 16'h1234;
        mem_img[8'h01] = 16'hA5C3;
        mem_img[8'h02] = 16'hDEAD;

        repeat (3) tick();
        cmp("rst_mem_req", 32'(bus.mem_req), 0);
        cmp("rst_mem_addr", 32'(bus.mem_addr), 0);
        cmp("rst_instr", 32'(bus.instr), 0);
        cmp("rst_instr_pc", 32'(bus.instr_pc), 0);
        cmp("rst_instr_valid", 32'(bus.instr_valid), 0);

        // First fetch from address 0, consumed immediately.
        rst_n = 1'b1;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        wait_valid("t1_valid");
        cmp("t1_instr", 32'(bus.instr), 'h1234);
        cmp("t1_instr_pc", 32'(bus.instr_pc), 0);
        tick();
        cmp("t1_valid_one_cycle", 32'(bus.instr_valid), 0);
        cmp("t1_next_addr", 32'(bus.mem_addr), 1);

        // Decode stalls for five cycles on 16'hA5C3.
        bus.instr_ready = 1'b0;
        wait_valid("t2_valid");
        cmp("t2_instr", 32'(bus.instr), 'hA5C3);
        lat_min = 2;
        lat_max = 2;
        repeat (5) begin
            tick();
            cmp("t2_hold_instr", 32'(bus.instr), 'hA5C3);
            cmp("t2_hold_valid", 32'(bus.instr_valid), 1);
            cmp("t2_hold_req", 32'(bus.mem_req), 0);
        end
        bus.instr_ready = 1'b1;
        wait_req("t2_req");
        cmp("t2_next_addr", 32'(bus.mem_addr), 2);

        // Redirect while the read of address 2 is outstanding.
        pc_load = 1'b1;
        pc_target = 8'h40;
        tick();
        pc_load = 1'b0;
        lat_min = 0;
        lat_max = 0;
        cmp("t3_addr_stable", 32'(bus.mem_addr), 2);
        cmp("t3_req_stable", 32'(bus.mem_req), 1);
        repeat (2) begin
            tick();
            cmp("t3_dropped", 32'(bus.instr_valid), 0);
        end
        wait_req("t3_req");
        cmp("t3_redirect_addr", 32'(bus.mem_addr), 'h40);

        // Redirect while holding, with decode ready at the same time.
        wait_valid("t4_valid");
        cmp("t4_instr_pc", 32'(bus.instr_pc), 'h40);
        pc_load = 1'b1;
        pc_target = 8'h80;
        tick();
        pc_load = 1'b0;
        cmp("t4_flushed", 32'(bus.instr_valid), 0);
        wait_req("t4_req");
        cmp("t4_redirect_addr", 32'(bus.mem_addr), 'h80);

        // PC wrap from 8'hFF to 8'h00.
        fetch_en = 1'b0;
        wait_valid("t5_valid_80");
        tick();
        pc_load = 1'b1;
        pc_target = 8'hFF;
        tick();
        pc_load = 1'b0;
        fetch_en = 1'b1;
        wait_req("t5_req_ff");
        cmp("t5_addr_ff", 32'(bus.mem_addr), 'hFF);
        wait_valid("t5_valid_ff");
        cmp("t5_instr_pc_ff", 32'(bus.instr_pc), 'hFF);
        lat_min = 3;
        lat_max = 3;
        tick();
        wait_req("t5_req_wrap");
        cmp("t5_wrap_addr", 32'(bus.mem_addr), 0);

        // Reset in the middle of a fetch, then a stray ack while idle.
        #2 rst_n = 1'b0;
        tick();
        cmp("t6_rst_req", 32'(bus.mem_req), 0);
        cmp("t6_rst_addr", 32'(bus.mem_addr), 0);
        cmp("t6_rst_valid", 32'(bus.instr_valid), 0);
        cmp("t6_rst_instr", 32'(bus.instr), 0);
        rst_n = 1'b1;
        fetch_en = 1'b0;
        force_stray = 1'b1;
        repeat (2) begin
            tick();
            cmp("t6_stray_valid", 32'(bus.instr_valid), 0);
            cmp("t6_stray_req", 32'(bus.mem_req), 0);
        end
        force_stray = 1'b0;
        lat_min = 0;
        lat_max = 0;
        fetch_en = 1'b1;
        wait_req("t6_restart_req");
        cmp("t6_restart_addr", 32'(bus.mem_addr), 0);
        wait_valid("t6_restart_valid");
        cmp("t6_restart_instr", 32'(bus.instr), 'h1234);

        // Randomised traffic: latencies, stalls, redirects, stray acks, resets.
        stray_rand = 1'b1;
        lat_min = 0;
        lat_max = 3;
        repeat (4000) begin
            tick();
            fetch_en = ($urandom % 8) != 0;
            pc_load = ($urandom % 12) == 0;
            pc_target = (($urandom % 4) == 0) ? 8'($urandom_range(255, 252)) : 8'($urandom);
            bus.instr_ready = ($urandom % 3) != 0;
            if (($urandom % 700) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
